// File: rtl/fetch_byte_queue_pkg.sv
// fetch_pkg: shared constants and byte/window types for the fetch byte queue and decoder.
package fetch_pkg;
    localparam int BUF_BYTES = 32;
    localparam int FETCH_BYTES = 8;
    localparam int WIN_BYTES = 15;
    typedef logic [7:0] byte_t;
    typedef logic [0:WIN_BYTES*8-1] win_t;
    typedef logic [0:FETCH_BYTES*8-1] fill_t;
endpackage

// File: rtl/fetch_byte_queue_if.sv
// fetch_byte_queue_if: fill, decode-window, consume and flush signals of the fetch byte queue.
interface fetch_byte_queue_if #(parameter int BUF_BYTES = fetch_pkg::BUF_BYTES);
    import fetch_pkg::*;
    logic                       flush;
    logic [63:0]                flush_pc;
    logic                       fill_valid;
    logic                       fill_ready;
    fill_t                      fill_data;
    win_t                       buffer_stream;
    logic                       window_valid;
    logic [$clog2(BUF_BYTES):0] avail_bytes;
    logic [63:0]                head_pc;
    logic                       consume;
    logic [3:0]                 byte_incr;
    logic                       protocol_err;
    modport master (
        output flush, flush_pc, fill_valid, fill_data, consume, byte_incr,
        input  fill_ready, buffer_stream, window_valid, avail_bytes, head_pc, protocol_err
    );
    modport slave (
        input  flush, flush_pc, fill_valid, fill_data, consume, byte_incr,
        output fill_ready, buffer_stream, window_valid, avail_bytes, head_pc, protocol_err
    );
endinterface

// File: rtl/fetch_byte_queue_ring.sv
// fbq_ring: circular byte storage with an 8-byte write port and a 15-byte rotated read port.
module fbq_ring import fetch_pkg::*; #(
    parameter int BUF_BYTES = fetch_pkg::BUF_BYTES,
    localparam int PW = $clog2(BUF_BYTES)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] wr_ptr_i,
    input  fill_t         wdata_i,
    input  logic [PW-1:0] rd_ptr_i,
    output win_t          rdata_o
);
    byte_t mem_q [BUF_BYTES];
    always_ff @(posedge clk)
        if (we_i)
            for (int i = 0; i < FETCH_BYTES; i++)
                mem_q[wr_ptr_i + PW'(i)] <= wdata_i[8*i +: 8];
    always_comb
        for (int k = 0; k < WIN_BYTES; k++)
            rdata_o[8*k +: 8] = mem_q[rd_ptr_i + PW'(k)];
endmodule

// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: instruction-byte ring feeding the decoder a 15-byte window at head_pc.
module fetch_byte_queue import fetch_pkg::*; #(
    parameter int BUF_BYTES = fetch_pkg::BUF_BYTES
) (
    input logic               clk,
    input logic               reset,
    fetch_byte_queue_if.slave bus
);
    localparam int PW = $clog2(BUF_BYTES);
    localparam int CW = PW + 1;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, incr;
    logic [63:0]   head_pc_q, head_pc_d;
    logic          err_q, err_d, do_fill, legal;
    win_t          raw;
    assign incr = CW'(bus.byte_incr);
    assign bus.fill_ready = count_q <= CW'(BUF_BYTES - FETCH_BYTES);
    assign do_fill = bus.fill_valid && bus.fill_ready && !bus.flush;
    assign legal = bus.consume && incr != '0 && incr <= count_q;
    always_comb begin
        rd_ptr_d  = bus.flush ? '0 : rd_ptr_q + (legal ? PW'(bus.byte_incr) : PW'(0));
        wr_ptr_d  = bus.flush ? '0 : wr_ptr_q + (do_fill ? PW'(FETCH_BYTES) : PW'(0));
        count_d   = bus.flush ? '0 : count_q + (do_fill ? CW'(FETCH_BYTES) : CW'(0)) - (legal ? incr : CW'(0));
        head_pc_d = bus.flush ? bus.flush_pc : head_pc_q + (legal ? 64'(bus.byte_incr) : 64'd0);
        err_d     = !bus.flush && bus.consume && !legal;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_pc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            err_q     <= err_d;
        end
    end
    fbq_ring #(.BUF_BYTES(BUF_BYTES)) u_ring (
        .clk      (clk),
        .we_i     (do_fill && reset),
        .wr_ptr_i (wr_ptr_q),
        .wdata_i  (bus.fill_data),
        .rd_ptr_i (rd_ptr_q),
        .rdata_o  (raw)
    );
    // Bytes beyond the held count are stale storage, so they are masked to zero.
    always_comb
        for (int k = 0; k < WIN_BYTES; k++)
            bus.buffer_stream[8*k +: 8] = (CW'(k) < count_q) ? raw[8*k +: 8] : 8'h00;
    assign bus.window_valid = count_q >= CW'(WIN_BYTES);
    assign bus.avail_bytes  = count_q;
    assign bus.head_pc      = head_pc_q;
    assign bus.protocol_err = err_q;
endmodule
